// File: rtl/ascii_hex_parser.sv
// ASCII hex entry parser: assembles typed hex digits into a value committed by a terminator.
// Optional terminal echo port enabled by defining ASCII_HEX_PARSER_ECHO_EN.
module ascii_hex_parser #(
  parameter int          DIGITS    = 4,
  parameter logic [7:0]  TERM_CHAR = 8'h0D,
  parameter logic [7:0]  BS_CHAR   = 8'h08,
  localparam int         W         = 4 * DIGITS,
  localparam int         CW        = $clog2(DIGITS + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [7:0]    char_in,
  input  logic          char_valid,
  output logic          char_ready,
  output logic [W-1:0]  value_out,
  output logic          value_valid,
  input  logic          value_ready,
  output logic [CW-1:0] digit_count,
  output logic          err,
  output logic [1:0]    dbg_state
`ifdef ASCII_HEX_PARSER_ECHO_EN
  ,
  output logic [7:0]    echo_char,
  output logic          echo_valid
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  value_q, value_d;
  logic          vvalid_q, vvalid_d;
  logic          err_q, err_d;
  logic          accept;
  logic          is_digit;
  logic [3:0]    nibble;
  logic          is_term;
  logic          is_bs;

  // Both ports use valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; the producer holds its data stable until that edge.
  assign char_ready  = (state_q != S_DONE);
  assign accept      = char_valid && char_ready;
  assign value_out   = value_q;
  assign value_valid = vvalid_q;
  assign digit_count = count_q;
  assign err         = err_q;
  assign dbg_state   = state_q;
  assign is_term     = (char_in == TERM_CHAR);
  assign is_bs       = (char_in == BS_CHAR);

  always_comb begin
    is_digit = 1'b0;
    nibble   = 4'd0;
    if (char_in >= 8'h30 && char_in <= 8'h39) begin
      is_digit = 1'b1;
      nibble   = char_in[3:0];
    end else if ((char_in >= 8'h41 && char_in <= 8'h46) ||
                 (char_in >= 8'h61 && char_in <= 8'h66)) begin
      is_digit = 1'b1;
      nibble   = char_in[3:0] + 4'd9;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    value_d  = value_q;
    vvalid_d = vvalid_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_digit) begin
            acc_d   = W'(nibble);
            count_d = CW'(1);
            state_d = S_ACCUM;
          end else if (!is_term && !is_bs) begin
            state_d = S_ERROR;
          end
        end
      end
      S_ACCUM: begin
        if (accept) begin
          if (is_digit) begin
            if (count_q == CW'(DIGITS)) begin
              acc_d   = '0;
              count_d = '0;
              state_d = S_ERROR;
            end else begin
              acc_d   = (acc_q << 4) | W'(nibble);
              count_d = count_q + CW'(1);
            end
          end else if (is_bs) begin
            acc_d   = acc_q >> 4;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
              acc_d   = '0;
              state_d = S_IDLE;
            end
          end else if (is_term) begin
            value_d  = acc_q;
            vvalid_d = 1'b1;
            count_d  = '0;
            state_d  = S_DONE;
          end else begin
            acc_d   = '0;
            count_d = '0;
            state_d = S_ERROR;
          end
        end
      end
      S_DONE: begin
        if (value_ready) begin
          vvalid_d = 1'b0;
          acc_d    = '0;
          count_d  = '0;
          state_d  = S_IDLE;
        end
      end
      S_ERROR: begin
        // Everything is swallowed until the terminator closes the bad entry.
        if (accept && is_term) begin
          err_d   = 1'b1;
          acc_d   = '0;
          count_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      count_q  <= '0;
      value_q  <= '0;
      vvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      value_q  <= value_d;
      vvalid_q <= vvalid_d;
      err_q    <= err_d;
    end
  end

`ifdef ASCII_HEX_PARSER_ECHO_EN
  logic [7:0] echo_char_q, echo_char_d;
  logic       echo_valid_q, echo_valid_d;

  always_comb begin
    echo_valid_d = accept;
    echo_char_d  = echo_char_q;
    if (accept) begin
      echo_char_d = (char_in >= 8'h61 && char_in <= 8'h66) ? (char_in - 8'h20) : char_in;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      echo_char_q  <= 8'h00;
      echo_valid_q <= 1'b0;
    end else begin
      echo_char_q  <= echo_char_d;
      echo_valid_q <= echo_valid_d;
    end
  end

  assign echo_char  = echo_char_q;
  assign echo_valid = echo_valid_q;
`endif

endmodule
